// File: rtl/ppe_tx_rcvr_if.sv
// Framed valid/ready beat stream shared by the tx input and the FIFO output of ppe_tx_rcvr.
// With PPE_TX_RCVR_PARITY_EN defined, `par` carries even parity (tx side) or the stored parity-error flag (out side).
interface ppe_tx_rcvr_if #(
    parameter int DATA_W = 32
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic              sop;
    logic              eop;
`ifdef PPE_TX_RCVR_PARITY_EN
    logic              par;

    modport master (output valid, data, sop, eop, par, input ready);
    modport slave  (input valid, data, sop, eop, par, output ready);
`else
    modport master (output valid, data, sop, eop, input ready);
    modport slave  (input valid, data, sop, eop, output ready);
`endif
endinterface

// File: rtl/ppe_tx_rcvr.sv
// PPE tx receiver: framing/length checks, FWFT beat FIFO, packet and error counters.
// Optional per-beat parity checking is enabled by defining PPE_TX_RCVR_PARITY_EN.
module ppe_tx_rcvr #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 16,
    parameter int MAX_LEN = 64
) (
    input  logic          clk,
    input  logic          rst,
    ppe_tx_rcvr_if.slave  tx,
    ppe_tx_rcvr_if.master out,
    output logic [15:0]   pkt_cnt,
    output logic [15:0]   err_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;

    typedef enum logic [1:0] {IDLE, PKT, DROP} state_t;

    state_t            state;
    logic [15:0]       bcnt;
    logic [15:0]       bcnt_inc;
    logic              at_max;

    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic [OW-1:0]     occ;
    logic              full;
    logic              nonempty;

    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  mem_s;
    logic [DEPTH-1:0]  mem_e;

    logic              acc;
    logic              pop;
    logic              wr;
    logic              wsop;
    logic              weop;
    logic              ferr;
    logic              err_inc;

    assign full     = (occ == OW'(DEPTH));
    assign nonempty = (occ != '0);
    assign tx.ready = (state == DROP) | ~full;
    assign acc      = tx.valid & tx.ready;
    assign pop      = nonempty & out.ready;

    // Length of the packet including the beat being offered now.
    assign bcnt_inc = (state == IDLE) ? 16'd1 : bcnt + 16'd1;
    assign at_max   = (bcnt_inc == 16'(MAX_LEN));

    always_comb begin
        wr   = 1'b0;
        wsop = 1'b0;
        weop = 1'b0;
        ferr = 1'b0;
        if (acc) begin
            case (state)
                IDLE: begin
                    if (tx.sop) begin
                        wr   = 1'b1;
                        wsop = 1'b1;
                        weop = tx.eop | at_max;
                        ferr = ~tx.eop & at_max;
                    end else begin
                        ferr = 1'b1;
                    end
                end
                PKT: begin
                    wr   = 1'b1;
                    weop = tx.eop | at_max;
                    ferr = tx.sop | (~tx.eop & at_max);
                end
                default: ;
            endcase
        end
    end

`ifdef PPE_TX_RCVR_PARITY_EN
    logic             wperr;
    logic [DEPTH-1:0] mem_p;

    // Discarded beats never reach the check because wr is already gated.
    assign wperr   = wr & (^{tx.data, tx.par});
    assign err_inc = ferr | wperr;
    assign out.par = nonempty & mem_p[rptr];

    always_ff @(posedge clk) begin
        if (wr) mem_p[wptr] <= wperr;
    end
`else
    assign err_inc = ferr;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            bcnt  <= '0;
        end else if (acc) begin
            case (state)
                IDLE: begin
                    bcnt <= bcnt_inc;
                    if (tx.sop && !tx.eop) state <= at_max ? DROP : PKT;
                end
                PKT: begin
                    bcnt <= bcnt_inc;
                    if (tx.eop)      state <= IDLE;
                    else if (at_max) state <= DROP;
                end
                DROP:    if (tx.eop) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            occ  <= '0;
        end else begin
            if (wr)  wptr <= wptr + AW'(1);
            if (pop) rptr <= rptr + AW'(1);
            occ <= occ + OW'(wr) - OW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (wr) begin
            mem_d[wptr] <= tx.data;
            mem_s[wptr] <= wsop;
            mem_e[wptr] <= weop;
        end
    end

    // Head fields read as zero while empty so reset shows clean outputs.
    assign out.valid = nonempty;
    assign out.data  = nonempty ? mem_d[rptr] : '0;
    assign out.sop   = nonempty & mem_s[rptr];
    assign out.eop   = nonempty & mem_e[rptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt <= '0;
            err_cnt <= '0;
        end else begin
            if (wr && weop)                     pkt_cnt <= pkt_cnt + 16'd1;
            if (err_inc && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_ppe_tx_rcvr.sv
// Directed bench for ppe_tx_rcvr: queue-based packet model checked every cycle plus literal spot checks.
module tb_ppe_tx_rcvr;
    localparam int DW      = 32;
    localparam int DEPTH   = 16;
    localparam int MAX_LEN = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pkt_cnt;
    logic [15:0] err_cnt;

    always #5 clk = ~clk;

    ppe_tx_rcvr_if #(.DATA_W(DW)) tx_if ();
    ppe_tx_rcvr_if #(.DATA_W(DW)) out_if ();

    ppe_tx_rcvr #(.DATA_W(DW), .DEPTH(DEPTH), .MAX_LEN(MAX_LEN)) dut (
        .clk    (clk),
        .rst    (rst),
        .tx     (tx_if),
        .out    (out_if),
        .pkt_cnt(pkt_cnt),
        .err_cnt(err_cnt)
    );

    typedef struct {
        logic [DW-1:0] d;
        logic          s;
        logic          e;
        logic          p;
    } beat_t;

    beat_t       mq[$];
    int          m_len;
    bit          m_in_pkt;
    bit          m_drop;
    logic [15:0] m_pkt;
    logic [15:0] m_err;
    logic        m_acc;
    logic        m_pop;
    logic        m_par;

    int nvec = 0;
    int nerr = 0;
    bit chk_en = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit m_ready();
        return m_drop || (mq.size() < DEPTH);
    endfunction

    function automatic void m_bump_err();
        if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
    endfunction

    // Packet rules: orphans and over-long tails are discarded, the MAX_LEN-th beat closes the packet.
    task automatic m_beat(logic [DW-1:0] d, logic s, logic e, logic par);
        beat_t b;
        bit    bad;
        if (m_drop) begin
            if (e) m_drop = 0;
            return;
        end
        if (!m_in_pkt && !s) begin
            m_bump_err();
            return;
        end
        bad   = m_in_pkt && s;
        m_len = m_in_pkt ? m_len + 1 : 1;
        b.d   = d;
        b.s   = !m_in_pkt;
        b.e   = e;
`ifdef PPE_TX_RCVR_PARITY_EN
        b.p   = ^{d, par};
`else
        b.p   = 1'b0 & par;
`endif
        m_in_pkt = 1;
        if (!e && m_len == MAX_LEN) begin
            b.e    = 1;
            bad    = 1;
            m_drop = 1;
        end
        if (b.e) begin
            m_in_pkt = 0;
            m_pkt    = m_pkt + 16'd1;
        end
        mq.push_back(b);
        if (bad || b.p) m_bump_err();
    endtask

`ifdef PPE_TX_RCVR_PARITY_EN
    assign m_par = tx_if.par;
`else
    assign m_par = 1'b0;
`endif

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_in_pkt = 0;
            m_drop   = 0;
            m_len    = 0;
            m_pkt    = '0;
            m_err    = '0;
        end else begin
            m_acc = tx_if.valid && m_ready();
            m_pop = (mq.size() != 0) && out_if.ready;
            if (m_pop) void'(mq.pop_front());
            if (m_acc) m_beat(tx_if.data, tx_if.sop, tx_if.eop, m_par);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("tx_ready", tx_if.ready, m_ready());
            chk("out_valid", out_if.valid, mq.size() != 0);
            if (mq.size() != 0) begin
                chk("out_data", out_if.data, mq[0].d);
                chk("out_sop", out_if.sop, mq[0].s);
                chk("out_eop", out_if.eop, mq[0].e);
`ifdef PPE_TX_RCVR_PARITY_EN
                chk("out_perr", out_if.par, mq[0].p);
`endif
            end
            chk("pkt_cnt", pkt_cnt, m_pkt);
            chk("err_cnt", err_cnt, m_err);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; returns just after the edge that accepted the beat.
    task automatic send(logic [DW-1:0] d, logic s, logic e, bit badpar = 0);
        bit rdy;
        int n;
        n = 0;
        tx_if.valid = 1'b1;
        tx_if.data  = d;
        tx_if.sop   = s;
        tx_if.eop   = e;
`ifdef PPE_TX_RCVR_PARITY_EN
        tx_if.par   = (^d) ^ badpar;
`endif
        do begin
            @(negedge clk);
            rdy = tx_if.ready;
            step();
            n++;
        end while (!rdy && n < 200);
        if (!rdy) begin
            nvec++;
            nerr++;
            $display("FAIL send_timeout: beat %0h never accepted", d);
        end
        tx_if.valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_if.ready = 1'b1;
        while (out_if.valid && n < 200) begin
            step();
            n++;
        end
        nvec++;
        if (out_if.valid) begin
            nerr++;
            $display("FAIL drain_timeout: out_valid still %0b", out_if.valid);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        tx_if.valid  = 1'b0;
        tx_if.data   = '0;
        tx_if.sop    = 1'b0;
        tx_if.eop    = 1'b0;
`ifdef PPE_TX_RCVR_PARITY_EN
        tx_if.par    = 1'b0;
`endif
        out_if.ready = 1'b0;
        step();
        chk_en = 1;
        step();
        rst = 1'b0;

        @(negedge clk);
        chk("rst_tx_ready", tx_if.ready, 1);
        chk("rst_out_valid", out_if.valid, 0);
        chk("rst_out_data", out_if.data, 0);
        chk("rst_pkt_cnt", pkt_cnt, 0);
        chk("rst_err_cnt", err_cnt, 0);
        step();

        // Single-beat packet
        out_if.ready = 1'b1;
        send(32'hA5A5_0001, 1, 1);
        @(negedge clk);
        chk("single_valid", out_if.valid, 1);
        chk("single_data", out_if.data, 32'hA5A5_0001);
        chk("single_sop", out_if.sop, 1);
        chk("single_eop", out_if.eop, 1);
        chk("single_pkt", pkt_cnt, 1);
        chk("single_err", err_cnt, 0);
        step();
        drain();

        // Fill to DEPTH, pop one, then the 17th beat goes in
        out_if.ready = 1'b0;
        for (int i = 0; i < 16; i++) send(DW'(i), i == 0, 0);
        tx_if.valid = 1'b1;
        tx_if.data  = 32'd16;
        tx_if.sop   = 1'b0;
        tx_if.eop   = 1'b1;
`ifdef PPE_TX_RCVR_PARITY_EN
        tx_if.par   = ^tx_if.data;
`endif
        @(negedge clk);
        chk("full_tx_ready", tx_if.ready, 0);
        chk("full_head", out_if.data, 0);
        out_if.ready = 1'b1;
        step();
        out_if.ready = 1'b0;
        @(negedge clk);
        chk("ready_after_pop", tx_if.ready, 1);
        chk("head_after_pop", out_if.data, 1);
        step();
        tx_if.valid = 1'b0;
        drain();

        // Over-length packet truncated at MAX_LEN, tail dropped
        for (int i = 1; i <= 70; i++) send(32'h3000_0000 + DW'(i), i == 1, i == 70);
        drain();
        @(negedge clk);
        chk("maxlen_err", err_cnt, 1);
        chk("maxlen_pkt", pkt_cnt, 3);
        step();
        send(32'h4000_0001, 1, 0);
        send(32'h4000_0002, 0, 1);
        drain();

        // Exactly MAX_LEN beats with eop on the last is legal
        for (int i = 1; i <= MAX_LEN; i++) send(32'h4100_0000 + DW'(i), i == 1, i == MAX_LEN);
        drain();
        @(negedge clk);
        chk("exact_err", err_cnt, 1);
        chk("exact_pkt", pkt_cnt, 5);
        step();

        // Orphan beat, then a packet with a stray sop on beat 2
        send(32'h5000_0000, 0, 0);
        send(32'h5000_0001, 1, 0);
        send(32'h5000_0002, 1, 0);
        send(32'h5000_0003, 0, 1);
        drain();
        @(negedge clk);
        chk("frame_err", err_cnt, 3);
        chk("frame_pkt", pkt_cnt, 6);
        step();

        // Reset with a partial packet buffered
        out_if.ready = 1'b0;
        for (int i = 0; i < 5; i++) send(32'h6000_0000 + DW'(i), i == 0, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", out_if.valid, 0);
        chk("midrst_tx_ready", tx_if.ready, 1);
        chk("midrst_pkt", pkt_cnt, 0);
        chk("midrst_err", err_cnt, 0);
        chk("midrst_sop", out_if.sop, 0);
        step();
        out_if.ready = 1'b1;
        send(32'h7000_0001, 1, 0);
        send(32'h7000_0002, 0, 1);
        drain();
        @(negedge clk);
        chk("postrst_pkt", pkt_cnt, 1);
        step();

`ifdef PPE_TX_RCVR_PARITY_EN
        out_if.ready = 1'b0;
        send(32'h0000_0001, 1, 1, 1);
        @(negedge clk);
        chk("par_perr", out_if.par, 1);
        chk("par_err", err_cnt, 1);
        step();
        drain();
`endif

        repeat (3) step();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
